// File: rtl/snapshot_collector_if.sv
// Bus bundle between the snapshot collector and its CPU, memory, aux-buffer and v_sync environment.
// master = the collector, slave = the surrounding system.
interface snapshot_collector_if #(
    parameter int DATA_WIDTH        = 16,
    parameter int MEM_ADDRESS_WIDTH = 11,
    parameter int AUX_ADDRESS_WIDTH = 6,
    parameter int CPU_ELEMENTS      = 10,
    parameter int MEM_CHANNELS      = 2
);
    localparam int CHW = $clog2(MEM_CHANNELS) + 1;

    logic                                      v_sync_in;
    logic [MEM_CHANNELS*MEM_ADDRESS_WIDTH-1:0] center_in;
    logic [DATA_WIDTH-1:0]                     cpu_content_in;
    logic [DATA_WIDTH-1:0]                     mem_data_in;
    logic [CPU_ELEMENTS-1:0]                   content_enable_out;
    logic [MEM_ADDRESS_WIDTH-1:0]              mem_address_out;
    logic [CHW-1:0]                            mem_channel_out;
    logic                                      aux_wr_out;
    logic [AUX_ADDRESS_WIDTH-1:0]              aux_waddress_out;
    logic [DATA_WIDTH-1:0]                     aux_data_out;
    logic                                      busy_out;
    logic                                      done_out;
    logic                                      overrun_out;

    modport master (
        input  v_sync_in, center_in, cpu_content_in, mem_data_in,
        output content_enable_out, mem_address_out, mem_channel_out, aux_wr_out,
               aux_waddress_out, aux_data_out, busy_out, done_out, overrun_out
    );

    modport slave (
        output v_sync_in, center_in, cpu_content_in, mem_data_in,
        input  content_enable_out, mem_address_out, mem_channel_out, aux_wr_out,
               aux_waddress_out, aux_data_out, busy_out, done_out, overrun_out
    );
endinterface

// File: rtl/snapshot_collector.sv
// Per-frame debug snapshot: CPU registers plus one clamped memory window per channel into the aux buffer.
// Optional checksum word at aux address TOTAL when SNAPSHOT_CRC_EN is defined.
module snapshot_collector #(
    parameter int DATA_WIDTH        = 16,
    parameter int MEM_ADDRESS_WIDTH = 11,
    parameter int AUX_ADDRESS_WIDTH = 6,
    parameter int CPU_ELEMENTS      = 10,
    parameter int MEM_CHANNELS      = 2,
    parameter int WINDOW            = 10
) (
    input logic                  clock_in,
    input logic                  reset_n_in,
    snapshot_collector_if.master bus
);
    localparam int AW        = MEM_ADDRESS_WIDTH;
    localparam int XW        = AUX_ADDRESS_WIDTH;
    localparam int DW        = DATA_WIDTH;
    localparam int CHW       = $clog2(MEM_CHANNELS) + 1;
    localparam int TOTAL     = CPU_ELEMENTS + MEM_CHANNELS * WINDOW;
    localparam int HALF      = WINDOW / 2 - 1;
    localparam int MAX_START = (1 << AW) - WINDOW;
`ifdef SNAPSHOT_CRC_EN
    localparam int LAST_SLOT = TOTAL;
`else
    localparam int LAST_SLOT = TOTAL - 1;
`endif

    typedef enum logic [2:0] {S_IDLE, S_CPU, S_MEM, S_CRC, S_DRAIN} state_e;
    typedef enum logic [1:0] {K_CPU, K_MEM, K_CRC} kind_e;

    state_e         state_q, state_d;
    logic [XW-1:0]  slot_q, slot_d;
    logic [CHW-1:0] chan_q, chan_d;
    logic [AW-1:0]  word_q, word_d;
    logic [AW-1:0]  start_q [MEM_CHANNELS];
    logic [AW-1:0]  start_d [MEM_CHANNELS];
    logic           vs_prev_q, vs_prev_d;
    logic [AW-1:0]  mem_addr_q, mem_addr_d;
    logic [CHW-1:0] mem_chan_q, mem_chan_d;
    logic           v1_q, v1_d;
    kind_e          kind1_q, kind1_d;
    logic [XW-1:0]  slot1_q, slot1_d;
    logic           last1_q, last1_d;
    logic [DW-1:0]  cpu_s1_q, cpu_s1_d;
    logic           aux_wr_q, aux_wr_d;
    logic [XW-1:0]  aux_addr_q, aux_addr_d;
    logic [DW-1:0]  aux_data_q, aux_data_d;
    logic           done_q, done_d;
    logic           overrun_q, overrun_d;
`ifdef SNAPSHOT_CRC_EN
    logic [DW-1:0]  crc_q, crc_d;
`endif

    logic          trig;
    logic [AW-1:0] cur_start, cur_addr;

    // Window start in AW+1 signed bits, clamped so the window never leaves 0..LAST.
    function automatic logic [AW-1:0] clamp_start(input logic [AW-1:0] c);
        logic signed [AW:0] s;
        s = $signed({1'b0, c}) - $signed((AW+1)'(HALF));
        if (s < 0) return '0;
        else if (s > $signed((AW+1)'(MAX_START))) return AW'(MAX_START);
        else return s[AW-1:0];
    endfunction

    assign trig = vs_prev_q && !bus.v_sync_in;

    always_comb begin
        cur_start = '0;
        for (int m = 0; m < MEM_CHANNELS; m++)
            if (chan_q == CHW'(m)) cur_start = start_q[m];
    end
    assign cur_addr = cur_start + word_q;

    always_comb begin
        // NOTE: every *_d gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        slot_d     = slot_q;
        chan_d     = chan_q;
        word_d     = word_q;
        start_d    = start_q;
        vs_prev_d  = bus.v_sync_in;
        mem_addr_d = mem_addr_q;
        mem_chan_d = mem_chan_q;
        v1_d       = 1'b0;
        kind1_d    = K_CPU;
        slot1_d    = slot_q;
        last1_d    = (slot_q == XW'(LAST_SLOT));
        cpu_s1_d   = bus.cpu_content_in;
        aux_wr_d   = v1_q;
        aux_addr_d = aux_addr_q;
        aux_data_d = aux_data_q;
        done_d     = v1_q && last1_q;
        overrun_d  = trig && (state_q != S_IDLE);
`ifdef SNAPSHOT_CRC_EN
        crc_d = aux_wr_q ? (crc_q ^ aux_data_q) : crc_q;
`endif

        // Second stage: CPU words get their second register, memory words their only one.
        if (v1_q) begin
            aux_addr_d = slot1_q;
            case (kind1_q)
                K_MEM:   aux_data_d = bus.mem_data_in;
`ifdef SNAPSHOT_CRC_EN
                K_CRC:   aux_data_d = crc_q ^ aux_data_q;
`endif
                default: aux_data_d = cpu_s1_q;
            endcase
        end

        if (state_q == S_MEM) begin
            mem_addr_d = cur_addr;
            mem_chan_d = chan_q;
        end

        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    state_d = S_CPU;
                    slot_d  = '0;
                    chan_d  = '0;
                    word_d  = '0;
                    for (int m = 0; m < MEM_CHANNELS; m++)
                        start_d[m] = clamp_start(bus.center_in[m*AW +: AW]);
`ifdef SNAPSHOT_CRC_EN
                    crc_d = '0;
`endif
                end
            end
            S_CPU: begin
                v1_d    = 1'b1;
                kind1_d = K_CPU;
                slot_d  = slot_q + XW'(1);
                if (slot_q == XW'(CPU_ELEMENTS - 1)) state_d = S_MEM;
            end
            S_MEM: begin
                v1_d    = 1'b1;
                kind1_d = K_MEM;
                slot_d  = slot_q + XW'(1);
                if (word_q == AW'(WINDOW - 1)) begin
                    word_d = '0;
                    if (chan_q == CHW'(MEM_CHANNELS - 1)) begin
`ifdef SNAPSHOT_CRC_EN
                        state_d = S_CRC;
`else
                        state_d = S_DRAIN;
`endif
                    end else begin
                        chan_d = chan_q + CHW'(1);
                    end
                end else begin
                    word_d = word_q + AW'(1);
                end
            end
            S_CRC: begin
                v1_d    = 1'b1;
                kind1_d = K_CRC;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (done_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the small start array is reset like any other flop; it is state, not a RAM.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q    <= S_IDLE;
            slot_q     <= '0;
            chan_q     <= '0;
            word_q     <= '0;
            for (int m = 0; m < MEM_CHANNELS; m++) start_q[m] <= '0;
            vs_prev_q  <= 1'b1;
            mem_addr_q <= '0;
            mem_chan_q <= '0;
            v1_q       <= 1'b0;
            kind1_q    <= K_CPU;
            slot1_q    <= '0;
            last1_q    <= 1'b0;
            cpu_s1_q   <= '0;
            aux_wr_q   <= 1'b0;
            aux_addr_q <= '0;
            aux_data_q <= '0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef SNAPSHOT_CRC_EN
            crc_q      <= '0;
`endif
        end else begin
            // NOTE: non-blocking only, so every flop samples pre-edge values regardless of order.
            state_q    <= state_d;
            slot_q     <= slot_d;
            chan_q     <= chan_d;
            word_q     <= word_d;
            start_q    <= start_d;
            vs_prev_q  <= vs_prev_d;
            mem_addr_q <= mem_addr_d;
            mem_chan_q <= mem_chan_d;
            v1_q       <= v1_d;
            kind1_q    <= kind1_d;
            slot1_q    <= slot1_d;
            last1_q    <= last1_d;
            cpu_s1_q   <= cpu_s1_d;
            aux_wr_q   <= aux_wr_d;
            aux_addr_q <= aux_addr_d;
            aux_data_q <= aux_data_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
`ifdef SNAPSHOT_CRC_EN
            crc_q      <= crc_d;
`endif
        end
    end

    assign bus.content_enable_out = (state_q == S_CPU) ? (CPU_ELEMENTS'(1) << slot_q) : '0;
    assign bus.mem_address_out    = (state_q == S_MEM) ? cur_addr : mem_addr_q;
    assign bus.mem_channel_out    = (state_q == S_MEM) ? chan_q : mem_chan_q;
    assign bus.aux_wr_out         = aux_wr_q;
    assign bus.aux_waddress_out   = aux_addr_q;
    assign bus.aux_data_out       = aux_data_q;
    assign bus.busy_out           = (state_q != S_IDLE);
    assign bus.done_out           = done_q;
    assign bus.overrun_out        = overrun_q;
endmodule
